// File: rtl/elevator_pkg.sv
// Shared elevator types: per-floor request state, default bank size and
// a floor-code validity helper used by the request bank.
package elevator_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } floor_state_t;

  localparam int DEFAULT_NUM_FLOORS = 4;

  // Wide enough for any encoded floor code the bank can be built with.
  localparam int CODE_W = 8;

  // A code is a real floor when it lies in 1..n; 0 and anything above n
  // mean "no key" or "between floors".
  function automatic logic floor_code_valid(input logic [CODE_W-1:0] code,
                                            input int unsigned       n);
    return (code != '0) && ({24'h0, code} <= n);
  endfunction

endpackage

// File: rtl/floor_cell.sv
// One floor's request latch: a two-state OFF/ON machine with clear priority.
// With FLOOR_REQ_CANCEL_EN defined, a cancel on an ON floor turns it off.
module floor_cell
  import elevator_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic set,
  input  logic clr,
`ifdef FLOOR_REQ_CANCEL_EN
  input  logic cancel,
`endif
  output logic is_on
);

  floor_state_t state_q;
  floor_state_t state_d;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: if (set) state_d = ON;
`ifdef FLOOR_REQ_CANCEL_EN
        ON:  if (cancel) state_d = OFF;
`else
        ON:  state_d = ON;
`endif
      endcase
    end
  end

  always_comb begin
    is_on = (state_q == ON);
  end

endmodule

// File: rtl/floor_request_bank.sv
// Elevator floor-call register: latches keypad presses per floor, clears on
// service, and picks the next target with a SCAN direction. Option: FLOOR_REQ_CANCEL_EN.
module floor_request_bank
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int FLOOR_W    = $clog2(NUM_FLOORS + 1)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [FLOOR_W-1:0]    KEY,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  Done,
  output logic [NUM_FLOORS-1:0] floor,
  output logic                  pending,
  output logic [FLOOR_W-1:0]    target,
  output logic                  dir_up
);

  logic [FLOOR_W-1:0]    key_q;
  logic                  key_valid;
  logic                  press;
  logic                  cur_valid;
  logic                  done_valid;
  logic [NUM_FLOORS-1:0] set_vec;
  logic [NUM_FLOORS-1:0] clr_vec;

  logic                  here_on;
  logic                  any_above;
  logic                  any_below;
  logic [FLOOR_W-1:0]    up_near;
  logic [FLOOR_W-1:0]    dn_near;
  logic [FLOOR_W-1:0]    low_near;

  // NOTE: key_q follows KEY even during reset, so a key held across reset
  // release is treated as already seen and raises no event.
  always_ff @(posedge Clock) begin
    key_q <= KEY;
  end

  always_comb begin
    key_valid  = floor_code_valid(CODE_W'(KEY), NUM_FLOORS);
    press      = key_valid && (KEY != key_q);
    cur_valid  = floor_code_valid(CODE_W'(cur_floor), NUM_FLOORS);
    done_valid = Done && cur_valid;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_vec[i] = press && (KEY == FLOOR_W'(i + 1));
      clr_vec[i] = done_valid && (cur_floor == FLOOR_W'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_cell
    floor_cell u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .set    (set_vec[g]),
      .clr    (clr_vec[g]),
`ifdef FLOOR_REQ_CANCEL_EN
      .cancel (set_vec[g]),
`endif
      .is_on  (floor[g])
    );
  end

  assign pending = |floor;

  // Descending scan leaves the lowest hit; ascending leaves the highest,
  // which gives nearest-above and nearest-below respectively.
  always_comb begin
    here_on   = 1'b0;
    any_above = 1'b0;
    any_below = 1'b0;
    up_near   = '0;
    dn_near   = '0;
    low_near  = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (floor[i]) low_near = FLOOR_W'(i + 1);
      if (floor[i] && cur_valid && ((i + 1) > int'(cur_floor))) begin
        any_above = 1'b1;
        up_near   = FLOOR_W'(i + 1);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor[i] && cur_valid && ((i + 1) < int'(cur_floor))) begin
        any_below = 1'b1;
        dn_near   = FLOOR_W'(i + 1);
      end
      if (floor[i] && cur_valid && ((i + 1) == int'(cur_floor))) here_on = 1'b1;
    end
  end

  always_comb begin
    target = '0;
    if (!cur_valid) begin
      target = low_near;
    end else if (here_on) begin
      target = cur_floor;
    end else if (dir_up) begin
      if (any_above)      target = up_near;
      else if (any_below) target = dn_near;
    end else begin
      if (any_below)      target = dn_near;
      else if (any_above) target = up_near;
    end
  end

  // Reverse only when the current sweep has run out of work ahead of the car.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dir_up <= 1'b1;
    end else if (cur_valid) begin
      if (dir_up && !any_above && any_below) begin
        dir_up <= 1'b0;
      end else if (!dir_up && !any_below && any_above) begin
        dir_up <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_floor_request_bank.sv
// Directed self-checking bench for floor_request_bank with NUM_FLOORS=4.
// Expectations follow FLOOR_REQ_CANCEL_EN when the macro is defined.
module tb_floor_request_bank;

  localparam int N = 4;
  localparam int W = 3;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [W-1:0] KEY;
  logic [W-1:0] cur_floor;
  logic         Done;
  logic [N-1:0] floor;
  logic         pending;
  logic [W-1:0] target;
  logic         dir_up;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  floor_request_bank #(.NUM_FLOORS(N)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .KEY       (KEY),
    .cur_floor (cur_floor),
    .Done      (Done),
    .floor     (floor),
    .pending   (pending),
    .target    (target),
    .dir_up    (dir_up)
  );

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; KEY = '0; cur_floor = 3'd1; Done = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    tick();
    check("rst_floor",   32'(floor),   32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_target",  32'(target),  32'h0);
    check("rst_dir",     32'(dir_up),  32'h1);

    // Held key 3 at floor 1: one event, target 3.
    KEY = 3'd3; tick();
    check("press3_floor",   32'(floor),   32'h4);
    check("press3_pending", 32'(pending), 32'h1);
    check("press3_target",  32'(target),  32'h3);
    repeat (4) tick();
    check("held_key_floor", 32'(floor), 32'h4);
    KEY = '0; tick();

    // Service floor 3.
    cur_floor = 3'd3; Done = 1'b1; tick(); Done = 1'b0;
    check("done3_floor",  32'(floor),  32'h0);
    check("done3_target", 32'(target), 32'h0);

    // At floor 2 going up with floors 1 and 4 pending.
    cur_floor = 3'd2;
    KEY = 3'd4; tick();
    KEY = 3'd1; tick();
    KEY = '0;   tick();
    check("f14_floor",  32'(floor),  32'h9);
    check("f14_dir",    32'(dir_up), 32'h1);
    check("f14_target", 32'(target), 32'h4);

    // Serve floor 4; next target is 1 and direction turns down.
    cur_floor = 3'd4; Done = 1'b1; tick(); Done = 1'b0;
    check("done4_floor",  32'(floor),  32'h1);
    check("done4_target", 32'(target), 32'h1);
    tick();
    check("done4_dir",    32'(dir_up), 32'h0);

    // Serve floor 1, then build a downward sweep from floor 3.
    cur_floor = 3'd1; Done = 1'b1; tick(); Done = 1'b0;
    check("done1_floor", 32'(floor), 32'h0);
    cur_floor = 3'd3;
    KEY = 3'd1; tick();
    KEY = 3'd4; tick();
    KEY = '0;   tick();
    check("down_target", 32'(target), 32'h1);
    check("down_dir",    32'(dir_up), 32'h0);
    KEY = 3'd2; tick();
    KEY = '0;   tick();
    check("down_floor",   32'(floor),  32'hb);
    check("down_nearest", 32'(target), 32'h2);

    // Press and Done on the same floor in one cycle: clear wins.
    cur_floor = 3'd2; KEY = 3'd2; Done = 1'b1; tick();
    check("clr_wins_on", 32'(floor), 32'h9);
    KEY = '0; Done = 1'b0; tick();
    KEY = 3'd2; Done = 1'b1; tick();
    check("clr_wins_off", 32'(floor), 32'h9);
    KEY = '0; Done = 1'b0; tick();
    KEY = 3'd2; tick();
    check("press_at_cur", 32'(floor),  32'hb);
    check("here_target",  32'(target), 32'h2);
    KEY = '0; Done = 1'b1; tick(); Done = 1'b0;
    check("clear_at_cur", 32'(floor), 32'h9);

    // Invalid cur_floor: lowest pending, Done ignored.
    cur_floor = 3'd0; #1;
    check("inv0_target", 32'(target), 32'h1);
    cur_floor = 3'd7; #1;
    check("inv7_target", 32'(target), 32'h1);
    Done = 1'b1; tick();
    cur_floor = 3'd0; tick(); Done = 1'b0;
    check("inv_done_floor", 32'(floor),  32'h9);
    check("inv_dir",        32'(dir_up), 32'h0);

    // Out-of-range keys, then direct code changes.
    cur_floor = 3'd2;
    KEY = 3'd5; tick();
    KEY = 3'd7; tick();
    check("bad_keys", 32'(floor), 32'h9);
    KEY = 3'd3; tick();
    check("key_7_to_3", 32'(floor), 32'hd);
    KEY = 3'd2; tick();
    check("key_3_to_2", 32'(floor), 32'hf);

    // Leave 4'b1010, then reset with a held key.
    KEY = '0; cur_floor = 3'd1; Done = 1'b1; tick();
    cur_floor = 3'd3; tick(); Done = 1'b0;
    check("pre_rst_floor", 32'(floor), 32'ha);
    Reset = 1'b1; KEY = 3'd4; tick();
    check("mid_rst_floor", 32'(floor),  32'h0);
    check("mid_rst_dir",   32'(dir_up), 32'h1);
    Reset = 1'b0; tick();
    check("held_thru_rst", 32'(floor), 32'h0);
    KEY = '0; tick();
    KEY = 3'd4; tick();
    check("post_rst_press", 32'(floor), 32'h8);

    // Second press on an ON floor.
    KEY = 3'd3; tick();
    check("cancel_first", 32'(floor[2]), 32'h1);
    KEY = '0; tick();
    KEY = 3'd3; tick();
`ifdef FLOOR_REQ_CANCEL_EN
    check("cancel_second", 32'(floor[2]), 32'h0);
`else
    check("cancel_second", 32'(floor[2]), 32'h1);
`endif
    KEY = '0; tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
